// File: rtl/imem_boot_sequencer.sv
// Boot sequencer: streams a big-endian program into instruction memory behind a
// forced NOP at word 0, then releases the core from reset for a fixed cycle count.
module imem_boot_sequencer #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned CYCLE_WIDTH = 16,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [ADDR_WIDTH-3:0]  load_len,
   input  logic [CYCLE_WIDTH-1:0] run_cycles,
   input  logic                   s_valid,
   input  logic [7:0]             s_byte,
   output logic                   s_ready,
   output logic                   imem_we,
   output logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   core_reset,
   output logic                   mem_en,
   output logic [CYCLE_WIDTH-1:0] cycle_count,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {S_IDLE, S_NOP_WR, S_LOAD, S_RUN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-3:0]  len_q, len_d;
   logic [ADDR_WIDTH-3:0]  ptr_q, ptr_d;
   logic [CYCLE_WIDTH-1:0] run_len_q, run_len_d;
   logic [1:0]             bidx_q, bidx_d;
   logic [23:0]            word_q, word_d;
   logic                   last_q, last_d;
   logic                   s_ready_q, s_ready_d;
   logic                   imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0]  imem_addr_q, imem_addr_d;
   logic [31:0]            imem_wdata_q, imem_wdata_d;
   logic                   core_reset_q, core_reset_d;
   logic                   mem_en_q, mem_en_d;
   logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   enter_exec;
   logic [CYCLE_WIDTH-1:0] cycle_nxt;

   // Outputs are computed for the state being entered, so they register alongside it.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      ptr_d        = ptr_q;
      run_len_d    = run_len_q;
      bidx_d       = bidx_q;
      word_d       = word_q;
      last_d       = last_q;
      s_ready_d    = s_ready_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      core_reset_d = core_reset_q;
      mem_en_d     = mem_en_q;
      cycle_d      = cycle_q;
      busy_d       = busy_q;
      done_d       = done_q;
      enter_exec   = 1'b0;
      cycle_nxt    = cycle_q + CYCLE_WIDTH'(1);

      if (abort) begin
         if (state_q != S_IDLE) begin
            state_d      = S_IDLE;
            core_reset_d = 1'b1;
            mem_en_d     = 1'b0;
            s_ready_d    = 1'b0;
            done_d       = 1'b0;
            busy_d       = 1'b0;
            bidx_d       = '0;
         end
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_d        = load_len;
                  run_len_d    = run_cycles;
                  state_d      = S_NOP_WR;
                  imem_we_d    = 1'b1;
                  imem_addr_d  = '0;
                  imem_wdata_d = NOP_WORD;
                  busy_d       = 1'b1;
                  done_d       = 1'b0;
                  cycle_d      = '0;
                  bidx_d       = '0;
               end
            end
            S_NOP_WR: begin
               if (len_q == '0) begin
                  enter_exec = 1'b1;
               end else begin
                  state_d   = S_LOAD;
                  s_ready_d = 1'b1;
                  ptr_d     = (ADDR_WIDTH-2)'(1);
               end
            end
            S_LOAD: begin
               if (imem_we_q) begin
                  if (last_q) enter_exec = 1'b1;
                  else        s_ready_d  = 1'b1;
               end else if (s_valid && s_ready_q) begin
                  bidx_d = bidx_q + 2'd1;
                  case (bidx_q)
                     2'd0: word_d[23:16] = s_byte;
                     2'd1: word_d[15:8]  = s_byte;
                     2'd2: word_d[7:0]   = s_byte;
                     default: begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = {ptr_q, 2'b00};
                        imem_wdata_d = {word_q, s_byte};
                        s_ready_d    = 1'b0;
                        last_d       = (ptr_q == len_q);
                        ptr_d        = ptr_q + (ADDR_WIDTH-2)'(1);
                     end
                  endcase
               end
            end
            S_RUN: begin
               cycle_d = cycle_nxt;
               if (cycle_nxt == run_len_q) begin
                  state_d      = S_DONE;
                  core_reset_d = 1'b1;
                  mem_en_d     = 1'b0;
                  done_d       = 1'b1;
                  busy_d       = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // A zero run length goes straight to DONE without ever releasing the core.
         if (enter_exec) begin
            if (run_len_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               state_d      = S_RUN;
               core_reset_d = 1'b0;
               mem_en_d     = 1'b1;
               busy_d       = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         len_q        <= '0;
         ptr_q        <= '0;
         run_len_q    <= '0;
         bidx_q       <= '0;
         word_q       <= '0;
         last_q       <= 1'b0;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_reset_q <= 1'b1;
         mem_en_q     <= 1'b0;
         cycle_q      <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         ptr_q        <= ptr_d;
         run_len_q    <= run_len_d;
         bidx_q       <= bidx_d;
         word_q       <= word_d;
         last_q       <= last_d;
         s_ready_q    <= s_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_reset_q <= core_reset_d;
         mem_en_q     <= mem_en_d;
         cycle_q      <= cycle_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign s_ready     = s_ready_q;
   assign imem_we     = imem_we_q;
   assign imem_addr   = imem_addr_q;
   assign imem_wdata  = imem_wdata_q;
   assign core_reset  = core_reset_q;
   assign mem_en      = mem_en_q;
   assign cycle_count = cycle_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
